// File: rtl/cache_2way_control.sv
// rtl/cache_2way_control.sv - control FSM for the 2-way set-associative L2 cache datapath
// Optional feature macro CACHE_PERF_CNT_EN adds hit/miss/writeback counters.
module cache_2way_control (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        mem_resp,
  input  logic        hit,
  input  logic        eviction,
  output logic        array_read,
  output logic        array_load,
  output logic        lru_load,
  output logic        pmdr_load,
  output logic        datawritemux_sel,
  output logic        adaptermux_sel,
  output logic        pmemaddrmux_sel,
  output logic        dirty_load,
  output logic        pmem_read,
  output logic        pmem_write,
  input  logic        pmem_resp
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [31:0] wb_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WB_LATCH,
    WRITEBACK,
    FILL
  } state_t;

  state_t state;
  state_t next_state;
  logic   rst_q;
  logic   req;

  assign req = mem_read | mem_write;

  // rst_q marks the first cycle after a reset edge, where every output stays low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
    rst_q <= rst;
  end

  always_comb begin
    next_state       = state;
    mem_resp         = 1'b0;
    array_read       = 1'b0;
    array_load       = 1'b0;
    lru_load         = 1'b0;
    pmdr_load        = 1'b0;
    datawritemux_sel = 1'b0;
    adaptermux_sel   = 1'b0;
    pmemaddrmux_sel  = 1'b0;
    dirty_load       = 1'b0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    if (!rst_q) begin
      case (state)
        IDLE: begin
          array_read = 1'b1;
          if (req) begin
            next_state = CHECK;
          end
        end
        CHECK: begin
          array_read = 1'b1;
          if (hit) begin
            mem_resp   = 1'b1;
            lru_load   = 1'b1;
            next_state = IDLE;
            if (mem_write) begin
              array_load       = 1'b1;
              datawritemux_sel = 1'b1;
              dirty_load       = 1'b1;
              adaptermux_sel   = 1'b1;
            end
          end else if (eviction) begin
            next_state = WB_LATCH;
          end else begin
            next_state = FILL;
          end
        end
        WB_LATCH: begin
          pmdr_load  = 1'b1;
          array_read = 1'b1;
          next_state = WRITEBACK;
        end
        WRITEBACK: begin
          pmem_write      = 1'b1;
          pmemaddrmux_sel = 1'b1;
          if (pmem_resp) begin
            next_state = FILL;
          end
        end
        FILL: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            array_load = 1'b1;
            dirty_load = 1'b1;
            next_state = CHECK;
          end
        end
        default: next_state = IDLE;
      endcase
      // A reset landing on a commit cycle must not leave a partial array/LRU update.
      if (rst) begin
        mem_resp   = 1'b0;
        array_load = 1'b0;
        lru_load   = 1'b0;
        pmdr_load  = 1'b0;
        dirty_load = 1'b0;
      end
    end
  end

`ifdef CACHE_PERF_CNT_EN
  state_t prev_state;

  // A hit right after FILL is the re-check of a miss, already counted as a miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_state <= IDLE;
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
      wb_count   <= 32'd0;
    end else begin
      prev_state <= state;
      if (state == CHECK && hit && prev_state != FILL) begin
        hit_count <= hit_count + 32'd1;
      end
      if (state == CHECK && !hit) begin
        miss_count <= miss_count + 32'd1;
      end
      if (state == WRITEBACK && pmem_resp) begin
        wb_count <= wb_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/cache_2way_control.md
Name: cache_2way_control

Overview:
- FSM that sequences the 2-way set-associative L2 cache datapath.
- Its outputs drive the datapath control inputs: array_read, array_load, lru_load, pmdr_load, datawritemux_sel, adaptermux_sel, pmemaddrmux_sel and dirty_load.
- It handles hits, dirty-victim writebacks and line fills, and runs the CPU-side and physical-memory-side request/response handshakes.
- Sits between the upstream cache/CPU port and the pmem port, alongside the datapath.

Parameters:
- none

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_read  in  1  upstream read request; held until mem_resp
- mem_write  in  1  upstream write request; held until mem_resp
- mem_resp  out  1  one-cycle completion pulse to upstream
- hit  in  1  datapath: tag match in either way
- eviction  in  1  datapath: LRU victim way is valid and dirty
- array_read  out  1  datapath: read tag/data/valid/dirty/LRU arrays
- array_load  out  1  datapath: write selected way's line, tag and valid
- lru_load  out  1  datapath: update LRU bit for set
- pmdr_load  out  1  datapath: latch victim line into writeback register
- datawritemux_sel  out  1  0 = line from pmem_rdata, 1 = line from mem_wdata
- adaptermux_sel  out  1  1 = dirty bit written as set, 0 = written as clear
- pmemaddrmux_sel  out  1  0 = request address, 1 = victim tag address
- dirty_load  out  1  datapath: write dirty bit of selected way
- pmem_read  out  1  pmem read request; held until pmem_resp
- pmem_write  out  1  pmem write request; held until pmem_resp
- pmem_resp  in  1  pmem completion pulse

Behaviour:
- One clock: clk. Reset is synchronous and active-high on rst.
- While rst is high at a clk edge: state <= IDLE. Every output is 0 in the cycle after the edge.
- Outputs are a Moore/Mealy mix decoded from state, hit, eviction, mem_write and pmem_resp. All outputs default to 0.
- States: IDLE, CHECK, WB_LATCH, WRITEBACK, FILL.
- IDLE:
  - array_read=1.
  - If mem_read|mem_write, go to CHECK.
- CHECK (arrays valid):
  - array_read=1.
  - Hit: mem_resp=1, lru_load=1, return to IDLE.
  - Hit with mem_write: additionally array_load=1, datawritemux_sel=1, dirty_load=1, adaptermux_sel=1.
  - Miss with eviction=1: go to WB_LATCH.
  - Miss with eviction=0: go to FILL.
- WB_LATCH: pmdr_load=1, array_read=1, go to WRITEBACK. This is one cycle, so victim data is registered before the pmem request.
- WRITEBACK:
  - pmem_write=1, pmemaddrmux_sel=1.
  - Hold until pmem_resp=1, then go to FILL.
- FILL:
  - pmem_read=1, pmemaddrmux_sel=0.
  - In the cycle pmem_resp=1: array_load=1, datawritemux_sel=0, dirty_load=1, adaptermux_sel=0, then go to CHECK. The re-check produces the hit and the response.
- Hit latency: mem_resp in the 2nd cycle after the request is sampled (IDLE→CHECK).
- Clean-miss latency: pmem latency + 3 cycles.
- Dirty-miss latency: adds WB_LATCH + writeback latency.
- mem_resp never asserts in the same cycle as pmem_read/pmem_write.
- mem_read and mem_write both high: treated as a write.
- pmem_resp in IDLE/CHECK/WB_LATCH is ignored.
- pmem_resp in the first cycle of WRITEBACK or FILL is accepted.
- Request dropped before mem_resp: protocol violation. The controller still completes the current transaction, then returns to IDLE.
- Reset mid-WRITEBACK/FILL: pmem_read/pmem_write drop on the next cycle. No partial array_load occurs. The pmem side must tolerate an abandoned request.
- Back-to-back requests: after mem_resp the FSM is in IDLE. A still-high request (the next one) is taken the following cycle, with a 1-cycle bubble.

Optional Feature:
- Macro: CACHE_PERF_CNT_EN.
- When defined, adds outputs:
  - hit_count [31:0]: +1 on each CHECK-state hit that produces mem_resp.
  - miss_count [31:0]: +1 on each CHECK→WB_LATCH/FILL transition.
  - wb_count [31:0]: +1 on each WRITEBACK exit.
- Counters wrap at 2^32 with no saturation and reset to 0 on rst.
- A miss re-check hit counts only as a miss, not as a hit. A hit_count increment is suppressed when the previous state was FILL.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Read hit: rst 2 cycles; mem_read=1, hit=1 → CHECK next cycle; mem_resp=1 and lru_load=1 for exactly 1 cycle, array_load=0, back to IDLE.
- Write hit: mem_write=1, hit=1 → in CHECK array_load=dirty_load=datawritemux_sel=adaptermux_sel=1 and mem_resp=1, same cycle.
- Clean miss: mem_read=1, hit=0, eviction=0; pmem_resp after 5 cycles → pmem_read high 6 cycles with pmemaddrmux_sel=0; fill cycle has array_load=1, datawritemux_sel=0, adaptermux_sel=0; hit=1 on re-check → mem_resp 1 cycle later.
- Dirty miss: hit=0, eviction=1 → pmdr_load 1 cycle, then pmem_write with pmemaddrmux_sel=1 until pmem_resp; then pmem_read; pmem_read and pmem_write never both high.
- Reset mid-fill: assert rst in 3rd FILL cycle → next cycle all outputs 0 and state IDLE; no array_load seen.
- With CACHE_PERF_CNT_EN: 3 hits, 2 clean misses, 1 dirty miss → hit_count=3, miss_count=3, wb_count=1.
